// File: rtl/perceptron_trainer.sv
// Single-layer perceptron training engine. It scans a binary sample bit-serially against
// its own weight/bias store, classifies the sample, and applies the saturating perceptron update rule.
module perceptron_trainer #(
    parameter int N_IN       = 8,
    parameter int W_W        = 8,
    parameter int LEARN_STEP = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    input  logic [N_IN-1:0]       sample_bits,
    input  logic                  sample_label,
    input  logic                  train_en,
    output logic                  result_valid,
    output logic                  result_class,
    output logic                  result_error,
    input  logic                  w_wr_en,
    input  logic [3:0]            w_wr_addr,
    input  logic [W_W-1:0]        w_wr_data,
    input  logic [3:0]            w_rd_addr,
    output logic [W_W-1:0]        w_rd_data
);

    localparam int ACC_W = W_W + $clog2(N_IN);
    localparam int SUM_W = ACC_W + 1;
    localparam int CNT_W = 4;
    localparam int IDX_W = $clog2(N_IN);
    localparam int UPD_W = W_W + 1;

    localparam logic [3:0]       BIAS_ADDR     = 4'(N_IN);
    localparam logic [CNT_W-1:0] CNT_LAST_SCAN = CNT_W'(N_IN - 1);
    localparam logic [CNT_W-1:0] CNT_BIAS      = CNT_W'(N_IN);
    localparam logic signed [UPD_W-1:0] STEP_POS = UPD_W'(LEARN_STEP);
    localparam logic signed [UPD_W-1:0] STEP_NEG = -STEP_POS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DECIDE = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t state;

    // Entries 0..N_IN-1 are the weights, entry N_IN is the bias.
    logic signed [W_W-1:0]   w [0:N_IN];
    logic [N_IN-1:0]         bits_q;
    logic                    label_q;
    logic                    train_q;
    logic                    class_q;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;

    logic [IDX_W-1:0]        idx;
    logic signed [W_W-1:0]   sel_w;
    logic signed [ACC_W-1:0] scan_term;
    logic signed [SUM_W-1:0] sum;
    logic                    sum_class;
    logic signed [UPD_W-1:0] upd_sum;
    logic signed [W_W-1:0]   upd_sat;

    assign idx          = cnt[IDX_W-1:0];
    assign sel_w        = w[cnt];
    assign scan_term    = bits_q[idx] ? {{(ACC_W-W_W){sel_w[W_W-1]}}, sel_w} : '0;
    assign sum          = {acc[ACC_W-1], acc} + {{(SUM_W-W_W){w[N_IN][W_W-1]}}, w[N_IN]};
    assign sum_class    = ~sum[SUM_W-1];
    assign sample_ready = (state == IDLE);

    // One extra bit of headroom exposes overflow as a mismatch of the two top bits.
    assign upd_sum = {sel_w[W_W-1], sel_w} + (label_q ? STEP_POS : STEP_NEG);

    always_comb begin
        upd_sat = upd_sum[W_W-1:0];
        if (upd_sum[W_W] != upd_sum[W_W-1]) begin
            upd_sat = upd_sum[W_W] ? {1'b1, {(W_W-1){1'b0}}} : {1'b0, {(W_W-1){1'b1}}};
        end
    end

    assign w_rd_data = (w_rd_addr <= BIAS_ADDR) ? w[w_rd_addr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            for (int i = 0; i <= N_IN; i++) begin
                w[i] <= '0;
            end
            bits_q       <= '0;
            label_q      <= 1'b0;
            train_q      <= 1'b0;
            class_q      <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            result_valid <= 1'b0;
            result_class <= 1'b0;
            result_error <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (w_wr_en && (w_wr_addr <= BIAS_ADDR)) begin
                        w[w_wr_addr] <= w_wr_data;
                    end
                    if (sample_valid) begin
                        bits_q  <= sample_bits;
                        label_q <= sample_label;
                        train_q <= train_en;
                        acc     <= '0;
                        cnt     <= '0;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    acc <= acc + scan_term;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST_SCAN) begin
                        state <= DECIDE;
                    end
                end
                DECIDE: begin
                    if (!train_q || (sum_class == label_q)) begin
                        result_valid <= 1'b1;
                        result_class <= sum_class;
                        result_error <= (sum_class != label_q);
                        state        <= IDLE;
                    end else begin
                        class_q <= sum_class;
                        cnt     <= '0;
                        state   <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (cnt == CNT_BIAS) begin
                        w[N_IN]      <= upd_sat;
                        result_valid <= 1'b1;
                        result_class <= class_q;
                        result_error <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        if (bits_q[idx]) begin
                            w[cnt] <= upd_sat;
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: directed scenarios with literal expectations, then random traffic
// checked every cycle against an arithmetic model of the classifier and its weight store.
module tb_perceptron_trainer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic [7:0] sample_bits = '0;
    logic       sample_label = 1'b0;
    logic       train_en = 1'b0;
    logic       result_valid;
    logic       result_class;
    logic       result_error;
    logic       w_wr_en = 1'b0;
    logic [3:0] w_wr_addr = '0;
    logic [7:0] w_wr_data = '0;
    logic [3:0] w_rd_addr = '0;
    logic [7:0] w_rd_data;

    perceptron_trainer #(.N_IN(8), .W_W(8), .LEARN_STEP(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_bits(sample_bits), .sample_label(sample_label), .train_en(train_en),
        .result_valid(result_valid), .result_class(result_class), .result_error(result_error),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    int          m_w [0:8];       // 0..7 weights, 8 bias
    int          last_due = 0;    // cycle of the pending result pulse; idle once reached
    logic [33:0] exp_q [$];       // {due cycle, class, error}
    logic        held_cls = 1'b0;
    logic        held_err = 1'b0;
    bit          checking = 1'b0;
    bit          m_exp_v;
    int          m_sum;
    int          m_d;
    int          m_due;
    logic        m_cls;
    logic        m_err;

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            m_exp_v = (exp_q.size() > 0) && (exp_q[0][33:2] == cyc);
            check("result_valid", int'(result_valid), int'(m_exp_v));
            if (m_exp_v) begin
                held_cls = exp_q[0][1];
                held_err = exp_q[0][0];
                void'(exp_q.pop_front());
            end
            check("result_class", int'(result_class), int'(held_cls));
            check("result_error", int'(result_error), int'(held_err));
            check("sample_ready", int'(sample_ready), int'(cyc >= last_due));
            if (cyc >= last_due) begin
                check("w_rd_data", int'($signed(w_rd_data)),
                      (w_rd_addr <= 4'd8) ? m_w[w_rd_addr] : 0);
            end
        end
        // Advance the model to what the coming rising edge does.
        if (!rst_n) begin
            for (int i = 0; i <= 8; i++) m_w[i] = 0;
            exp_q.delete();
            last_due = 0;
            held_cls = 1'b0;
            held_err = 1'b0;
            checking = 1'b1;
        end else if (cyc >= last_due) begin
            if (w_wr_en && (w_wr_addr <= 4'd8)) m_w[w_wr_addr] = int'($signed(w_wr_data));
            if (sample_valid) begin
                m_sum = m_w[8];
                for (int i = 0; i < 8; i++) if (sample_bits[i]) m_sum += m_w[i];
                m_cls = (m_sum >= 0);
                m_err = (m_cls != sample_label);
                if (train_en && m_err) begin
                    m_d = sample_label ? 16 : -16;
                    for (int i = 0; i < 8; i++) if (sample_bits[i]) m_w[i] = sat8(m_w[i] + m_d);
                    m_w[8] = sat8(m_w[8] + m_d);
                    m_due = cyc + 1 + 18;
                end else begin
                    m_due = cyc + 1 + 9;
                end
                exp_q.push_back({m_due[31:0], m_cls, m_err});
                last_due = m_due;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int acc_edge);
        int n;
        n = 0;
        @(negedge clk);
        while (!sample_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!sample_ready) check("accept_timeout", 0, 1);
        acc_edge = cyc + 1;
    endtask

    task automatic send(input logic [7:0] bits, input logic lbl, input logic tr,
                        output int acc_edge);
        sample_valid = 1'b1;
        sample_bits  = bits;
        sample_label = lbl;
        train_en     = tr;
        wait_ready(acc_edge);
        tick();
        sample_valid = 1'b0;
        sample_bits  = 8'($urandom);
        sample_label = 1'($urandom);
        train_en     = 1'($urandom);
    endtask

    task automatic wait_result(input int acc_edge, input int lat, input string name,
                               output logic cls, output logic err);
        int n;
        n = 0;
        @(negedge clk);
        while (!result_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!result_valid) check({name, "_timeout"}, 0, 1);
        else check({name, "_latency"}, cyc - acc_edge, lat);
        cls = result_class;
        err = result_error;
    endtask

    task automatic load(input int addr, input int data);
        tick();
        w_wr_en   = 1'b1;
        w_wr_addr = 4'(addr);
        w_wr_data = 8'(data);
        tick();
        w_wr_en   = 1'b0;
    endtask

    task automatic rd(input int addr, input int exp, input string name);
        tick();
        w_rd_addr = 4'(addr);
        @(negedge clk);
        check(name, int'($signed(w_rd_data)), exp);
    endtask

    // ---------------- stimulus ----------------
    int   a1;
    int   a2;
    int   pulses;
    logic c;
    logic e;

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset state
        for (int a = 0; a <= 8; a++) rd(a, 0, $sformatf("reset_rd%0d", a));
        check("reset_ready", int'(sample_ready), 1);
        check("reset_valid", int'(result_valid), 0);
        check("reset_class", int'(result_class), 0);
        check("reset_error", int'(result_error), 0);

        // All-ones sample on zero weights, inference only
        tick();
        send(8'hFF, 1'b1, 1'b0, a1);
        wait_result(a1, 9, "infer_ff", c, e);
        check("infer_ff_class", int'(c), 1);
        check("infer_ff_error", int'(e), 0);
        rd(3, 0, "infer_ff_w3");

        // Misclassified sample with training
        tick();
        send(8'h0F, 1'b0, 1'b1, a1);
        wait_result(a1, 18, "train_0f", c, e);
        check("train_0f_class", int'(c), 1);
        check("train_0f_error", int'(e), 1);
        rd(0, -16, "train_0f_w0");
        rd(3, -16, "train_0f_w3");
        rd(4, 0, "train_0f_w4");
        rd(8, -16, "train_0f_bias");
        tick();
        send(8'h0F, 1'b0, 1'b0, a1);
        wait_result(a1, 9, "rerun_0f", c, e);
        check("rerun_0f_class", int'(c), 0);
        check("rerun_0f_error", int'(e), 0);

        // Saturation on update
        load(0, -120);
        load(1, 127);
        load(8, 0);
        tick();
        send(8'h03, 1'b0, 1'b1, a1);
        wait_result(a1, 18, "sat", c, e);
        check("sat_class", int'(c), 1);
        check("sat_error", int'(e), 1);
        rd(0, -128, "sat_w0");
        rd(1, 111, "sat_w1");
        rd(8, -16, "sat_bias");

        // Back-to-back with valid held high; load attempt during SCAN
        tick();
        sample_valid = 1'b1;
        sample_bits  = 8'h01;
        sample_label = 1'b1;
        train_en     = 1'b0;
        wait_ready(a1);
        tick();
        sample_bits  = 8'h02;
        wait_result(a1, 9, "b2b_first", c, e);
        check("b2b_first_class", int'(c), 0);
        check("b2b_first_error", int'(e), 1);
        check("b2b_ready_in_pulse", int'(sample_ready), 1);
        a2 = cyc + 1;
        tick();
        sample_valid = 1'b0;
        w_wr_en   = 1'b1;
        w_wr_addr = 4'd1;
        w_wr_data = 8'd0;
        tick();
        w_wr_en   = 1'b0;
        wait_result(a2, 9, "b2b_second", c, e);
        check("b2b_second_class", int'(c), 1);
        check("b2b_second_error", int'(e), 0);
        rd(1, 111, "scan_load_ignored_w1");

        // Reset in the middle of UPDATE
        tick();
        send(8'hFF, 1'b1, 1'b1, a1);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        rd(1, 0, "abort_w1");
        rd(8, 0, "abort_bias");
        check("abort_ready", int'(sample_ready), 1);

        // Random traffic against the model
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 2) == 0) load($urandom_range(0, 10), int'($urandom_range(0, 255)));
            tick();
            w_rd_addr = 4'($urandom);
            w_wr_en   = ($urandom_range(0, 5) == 0);
            w_wr_addr = 4'($urandom_range(0, 9));
            w_wr_data = 8'($urandom);
            send(8'($urandom), 1'($urandom), 1'($urandom), a1);
            w_wr_en = 1'b0;
            repeat ($urandom_range(0, 22)) begin
                tick();
                w_rd_addr = 4'($urandom);
                w_wr_en   = ($urandom_range(0, 7) == 0);
                w_wr_addr = 4'($urandom_range(0, 10));
                w_wr_data = 8'($urandom);
            end
            w_wr_en = 1'b0;
        end
        repeat (25) begin
            tick();
            w_rd_addr = 4'($urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
On-chip training engine for the single-layer perceptron classifier. Accepts an 8-bit binary feature sample, a target label and a train-enable flag. Scans the sample bit-serially to accumulate the weighted sum, then classifies. On a misclassification with training enabled, it applies the perceptron update rule to the weight and bias store it owns. It also acts as the writer side of that store: a direct load port and a combinational read port let the classifier path and test logic preload and observe weights.

Parameters:
N_IN, 8, number of feature bits/weights (index 0..N_IN-1)
W_W, 8, weight/bias width, signed two's complement
LEARN_STEP, 16, unsigned update magnitude added/subtracted per update (1..127)

Ports:
clk  input  1  clock
rst_n  input  1  reset
sample_valid  input  1  sample offer
sample_ready  output  1  high exactly when FSM in IDLE
sample_bits  input  N_IN  feature bits; bit i pairs with weight i
sample_label  input  1  target class (0/1)
train_en  input  1  1 = update on error, 0 = inference only
result_valid  output  1  one-cycle pulse, result available
result_class  output  1  computed class, held until next result
result_error  output  1  class != label, held until next result
w_wr_en  input  1  direct weight/bias load strobe
w_wr_addr  input  4  0..N_IN-1 = weight, N_IN = bias, others ignored
w_wr_data  input  W_W  signed load value
w_rd_addr  input  4  read select, same map as write; others read 0
w_rd_data  output  W_W  combinational read of selected weight/bias

Behaviour:
- Reset rst_n, synchronous, active-low; clock clk. Reset returns FSM to IDLE and clears all weights, bias, accumulator, bit counter, result_valid, result_class and result_error to 0. Reset mid-SCAN/UPDATE aborts with no result pulse.
- States: IDLE, SCAN, DECIDE, UPDATE.
  - IDLE: on sample_valid && sample_ready (edge k), latch sample_bits, label and train_en; clear the accumulator and counter; go to SCAN. Input changes after acceptance are ignored.
  - SCAN: N_IN edges (k+1..k+8). Bit index 0 is first. acc += sample[i] ? sext(w[i]) : 0.
    - acc width W_W+3 signed (11 bits); no overflow is possible.
  - DECIDE: one edge (k+9). Compute sum = acc + sext(bias) at 12-bit signed. class = (sum >= 0).
    - If !train_en or class == label: load the result registers, pulse result_valid, return to IDLE.
    - Otherwise go to UPDATE.
  - UPDATE: N_IN+1 edges (k+10..k+18).
    - Indices 0..N_IN-1: if sample bit set, w[i] = sat(w[i] + d), else unchanged.
    - Index N_IN: bias = sat(bias + d).
    - d = +LEARN_STEP if label = 1, -LEARN_STEP if label = 0.
    - The final edge loads the result registers with result_error = 1, pulses result_valid and returns to IDLE.
- Saturation: clamp to [-128, +127]. The computation must not wrap.
- Latency from acceptance edge to result_valid: 9 edges without update, 18 edges with update.
- result_valid and sample_ready rise on the same edge, so the next sample may be accepted in the pulse cycle (back-to-back allowed).
- Direct load: honoured only in IDLE; ignored in any other state. Load with simultaneous sample acceptance: both occur, and SCAN uses the newly loaded value.
- Read port: pure combinational. During UPDATE it reflects each write on the following cycle.

Test Plan:
- Reset, then read addresses 0..8 -> all reads return 0; sample_ready=1; result_valid=0, result_class=0, result_error=0.
- Zero weights; sample 0xFF, label 1, train_en=0 -> result_valid 9 edges after acceptance; class=1, error=0; weights unchanged.
- Zero weights; sample 0x0F, label 0, train_en=1 -> class=1, error=1; result at 18 edges; w0..w3 = -16, w4..w7 = 0, bias = -16. Re-run same sample with train_en=0 -> sum = -80, class=0, error=0.
- Load w0=-120, w1=127, bias=0; sample 0x03, label 0, train_en=1 -> sum = 7, class=1, error=1; w0 = -128 (saturated), w1 = 111, bias = -16.
- Back-to-back: hold sample_valid high across two samples -> second accepted on the result_valid edge with no idle gap. Assert w_wr_en during SCAN -> target weight unchanged.
- Assert rst_n=0 for one edge mid-UPDATE -> FSM in IDLE, all weights/bias 0, no result_valid pulse.
